// File: rtl/reg_bank_32x32.sv
// Purpose: 32x32-bit register bank (r0 hardwired to zero) with a per-register busy scoreboard.
// Latency: writes and busy set/clear are visible one clk edge later; rsv_stall is combinational.
// Backpressure: rsv_stall refuses a reservation of an already-busy register; writes never stall.
// Optional feature: define REG_BANK_SCOREBOARD_EN to build the busy scoreboard; otherwise busy and rsv_stall are zero.
module reg_bank_32x32 (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [4:0]  wr_addr,
   input  logic [31:0] wr_data,
   input  logic        rsv_en,
   input  logic [4:0]  rsv_addr,
   output logic        rsv_stall,
   output logic [31:0] busy,
   output logic [31:0] Q0,
   output logic [31:0] Q1,
   output logic [31:0] Q2,
   output logic [31:0] Q3,
   output logic [31:0] Q4,
   output logic [31:0] Q5,
   output logic [31:0] Q6,
   output logic [31:0] Q7,
   output logic [31:0] Q8,
   output logic [31:0] Q9,
   output logic [31:0] Q10,
   output logic [31:0] Q11,
   output logic [31:0] Q12,
   output logic [31:0] Q13,
   output logic [31:0] Q14,
   output logic [31:0] Q15,
   output logic [31:0] Q16,
   output logic [31:0] Q17,
   output logic [31:0] Q18,
   output logic [31:0] Q19,
   output logic [31:0] Q20,
   output logic [31:0] Q21,
   output logic [31:0] Q22,
   output logic [31:0] Q23,
   output logic [31:0] Q24,
   output logic [31:0] Q25,
   output logic [31:0] Q26,
   output logic [31:0] Q27,
   output logic [31:0] Q28,
   output logic [31:0] Q29,
   output logic [31:0] Q30,
   output logic [31:0] Q31
);

   // Storage exists only for r1..r31; r0 is a constant.
   logic [31:1][31:0] regs_q;
   logic [31:1][31:0] regs_d;
   logic              wr_hit;

   assign wr_hit = wr_en && (wr_addr != 5'd0);

   // Next register contents: load wr_data into the addressed register, r0 writes dropped.
   always_comb begin
      regs_d = regs_q;
      if (wr_hit) begin
         regs_d[wr_addr] = wr_data;
      end
   end

   // Register storage with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

`ifdef REG_BANK_SCOREBOARD_EN
   logic [31:0] busy_q;
   logic [31:0] busy_d;

   // Stall only depends on the current busy state, never on the same-cycle write.
   assign rsv_stall = rsv_en && busy_q[rsv_addr] && (rsv_addr != 5'd0);

   // Scoreboard update: clear on write-back first, then set on accepted reserve so the reservation wins.
   always_comb begin
      busy_d = busy_q;
      if (wr_hit) begin
         busy_d[wr_addr] = 1'b0;
      end
      if (rsv_en && (rsv_addr != 5'd0) && !rsv_stall) begin
         busy_d[rsv_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Busy flags with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy = busy_q;
`else
   // Without the scoreboard the reserve port is inert.
   logic unused_rsv;
   assign unused_rsv = ^{rsv_en, rsv_addr};
   assign busy       = 32'h0;
   assign rsv_stall  = 1'b0;
`endif

   assign Q0  = 32'h0;
   assign Q1  = regs_q[1];
   assign Q2  = regs_q[2];
   assign Q3  = regs_q[3];
   assign Q4  = regs_q[4];
   assign Q5  = regs_q[5];
   assign Q6  = regs_q[6];
   assign Q7  = regs_q[7];
   assign Q8  = regs_q[8];
   assign Q9  = regs_q[9];
   assign Q10 = regs_q[10];
   assign Q11 = regs_q[11];
   assign Q12 = regs_q[12];
   assign Q13 = regs_q[13];
   assign Q14 = regs_q[14];
   assign Q15 = regs_q[15];
   assign Q16 = regs_q[16];
   assign Q17 = regs_q[17];
   assign Q18 = regs_q[18];
   assign Q19 = regs_q[19];
   assign Q20 = regs_q[20];
   assign Q21 = regs_q[21];
   assign Q22 = regs_q[22];
   assign Q23 = regs_q[23];
   assign Q24 = regs_q[24];
   assign Q25 = regs_q[25];
   assign Q26 = regs_q[26];
   assign Q27 = regs_q[27];
   assign Q28 = regs_q[28];
   assign Q29 = regs_q[29];
   assign Q30 = regs_q[30];
   assign Q31 = regs_q[31];

endmodule

// File: tb/tb_reg_bank_32x32.sv
// Testbench for reg_bank_32x32: directed scenarios plus randomized traffic against a reference model.
// Expectations follow the build: REG_BANK_SCOREBOARD_EN enables the busy model.
module tb_reg_bank_32x32;

`ifdef REG_BANK_SCOREBOARD_EN
   localparam bit SB_EN = 1'b1;
`else
   localparam bit SB_EN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        rsv_en;
   logic [4:0]  rsv_addr;
   logic        rsv_stall;
   logic [31:0] busy;
   logic [31:0] q [32];

   // Reference model: architectural register values and pending-write set.
   logic [31:0] m_reg [32];
   bit          m_busy [32];

   int checks = 0;
   int errors = 0;

   reg_bank_32x32 dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .rsv_stall(rsv_stall), .busy(busy),
      .Q0(q[0]),   .Q1(q[1]),   .Q2(q[2]),   .Q3(q[3]),
      .Q4(q[4]),   .Q5(q[5]),   .Q6(q[6]),   .Q7(q[7]),
      .Q8(q[8]),   .Q9(q[9]),   .Q10(q[10]), .Q11(q[11]),
      .Q12(q[12]), .Q13(q[13]), .Q14(q[14]), .Q15(q[15]),
      .Q16(q[16]), .Q17(q[17]), .Q18(q[18]), .Q19(q[19]),
      .Q20(q[20]), .Q21(q[21]), .Q22(q[22]), .Q23(q[23]),
      .Q24(q[24]), .Q25(q[25]), .Q26(q[26]), .Q27(q[27]),
      .Q28(q[28]), .Q29(q[29]), .Q30(q[30]), .Q31(q[31])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model_busy_vec();
      logic [31:0] v;
      v = 32'h0;
      for (int i = 1; i < 32; i++) v[i] = m_busy[i];
      return v;
   endfunction

   function automatic bit model_stall();
      return SB_EN && rsv_en && (rsv_addr != 0) && m_busy[rsv_addr];
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) begin
         m_reg[i]  = 32'h0;
         m_busy[i] = 1'b0;
      end
   endfunction

   // Advance the model by one edge using the present inputs, then step the DUT past the edge.
   task automatic tick();
      bit st;
      st = model_stall();
      if (wr_en && wr_addr != 0) begin
         m_reg[wr_addr]  = wr_data;
         m_busy[wr_addr] = 1'b0;
      end
      if (SB_EN && rsv_en && rsv_addr != 0 && !st) m_busy[rsv_addr] = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                        input bit re, input logic [4:0] ra);
      wr_en = we; wr_addr = wa; wr_data = wd; rsv_en = re; rsv_addr = ra;
   endtask

   task automatic test_reset();
      drive(0, 0, 0, 1, 5'd3);
      #1;
      checks++;
      if (busy !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h want 00000000", busy); end
      checks++;
      if (rsv_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", rsv_stall); end
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (q[i] !== 32'h0) begin errors++; $display("FAIL reset_q%0d: got %h want 00000000", i, q[i]); end
      end
      rst = 1'b0;
      drive(1, 5'd5, 32'hDEAD_BEEF, 0, 0);
      tick();
      checks++;
      if (q[5] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_r5: got %h want deadbeef", q[5]); end
      drive(0, 0, 0, 0, 0);
      #2 rst = 1'b1;
      #1;
      model_reset();
      checks++;
      if (q[5] !== 32'h0) begin errors++; $display("FAIL async_reset_q5: got %h want 00000000", q[5]); end
      checks++;
      if (busy !== 32'h0) begin errors++; $display("FAIL async_reset_busy: got %h want 00000000", busy); end
      #1 rst = 1'b0;
      drive(1, 5'd0, 32'hFFFF_FFFF, 0, 0);
      tick();
      checks++;
      if (q[0] !== 32'h0) begin errors++; $display("FAIL r0_write: got %h want 00000000", q[0]); end
   endtask

   task automatic test_write_readback();
      drive(1, 5'd7, 32'h1234_5678, 0, 0);
      tick();
      checks++;
      if (q[7] !== 32'h1234_5678) begin errors++; $display("FAIL wb_r7: got %h want 12345678", q[7]); end
      checks++;
      if (q[31] !== 32'h0) begin errors++; $display("FAIL wb_r31_early: got %h want 00000000", q[31]); end
      drive(1, 5'd31, 32'h8000_0001, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      checks++;
      if (q[31] !== 32'h8000_0001) begin errors++; $display("FAIL wb_r31: got %h want 80000001", q[31]); end
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (q[i] !== m_reg[i]) begin errors++; $display("FAIL wb_q%0d: got %h want %h", i, q[i], m_reg[i]); end
      end
   endtask

   task automatic test_reserve_stall();
      drive(0, 0, 0, 1, 5'd3);
      tick();
      checks++;
      if (busy !== (SB_EN ? 32'h0000_0008 : 32'h0)) begin
         errors++; $display("FAIL rsv_r3_busy: got %h want %h", busy, SB_EN ? 32'h8 : 32'h0);
      end
      #1;
      checks++;
      if (rsv_stall !== SB_EN) begin errors++; $display("FAIL rsv_r3_again_stall: got %b want %b", rsv_stall, SB_EN); end
      tick();
      checks++;
      if (busy !== model_busy_vec()) begin errors++; $display("FAIL rsv_r3_again_busy: got %h want %h", busy, model_busy_vec()); end
      drive(1, 5'd3, 32'hA5A5_A5A5, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      checks++;
      if (busy !== 32'h0) begin errors++; $display("FAIL wr_r3_busy: got %h want 00000000", busy); end
      checks++;
      if (q[3] !== 32'hA5A5_A5A5) begin errors++; $display("FAIL wr_r3_q: got %h want a5a5a5a5", q[3]); end
   endtask

   task automatic test_simultaneous();
      drive(1, 5'd4, 32'h0000_00FF, 1, 5'd4);
      #1;
      checks++;
      if (rsv_stall !== 1'b0) begin errors++; $display("FAIL sim_same_stall: got %b want 0", rsv_stall); end
      tick();
      checks++;
      if (q[4] !== 32'h0000_00FF) begin errors++; $display("FAIL sim_same_q4: got %h want 000000ff", q[4]); end
      checks++;
      if (busy[4] !== SB_EN) begin errors++; $display("FAIL sim_same_busy4: got %b want %b", busy[4], SB_EN); end
      drive(1, 5'd4, 32'h0000_0044, 1, 5'd9);
      tick();
      drive(0, 0, 0, 0, 0);
      checks++;
      if (busy[9] !== SB_EN) begin errors++; $display("FAIL sim_diff_busy9: got %b want %b", busy[9], SB_EN); end
      checks++;
      if (busy[4] !== 1'b0) begin errors++; $display("FAIL sim_diff_busy4: got %b want 0", busy[4]); end
      checks++;
      if (q[4] !== 32'h0000_0044) begin errors++; $display("FAIL sim_diff_q4: got %h want 00000044", q[4]); end
   endtask

   task automatic test_mid_reset();
      logic [4:0] seq [4];
      seq[0] = 5'd1; seq[1] = 5'd2; seq[2] = 5'd9; seq[3] = 5'd10;
      drive(1, 5'd1, 32'h0000_0011, 0, 0);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 1, seq[i]);
         tick();
      end
      drive(0, 0, 0, 0, 0);
      checks++;
      if (busy !== (SB_EN ? 32'h0000_0606 : 32'h0)) begin
         errors++; $display("FAIL pre_reset_busy: got %h want %h", busy, SB_EN ? 32'h606 : 32'h0);
      end
      checks++;
      if (q[1] !== 32'h0000_0011) begin errors++; $display("FAIL pre_reset_q1: got %h want 00000011", q[1]); end
      #2 rst = 1'b1;
      #1;
      model_reset();
      checks++;
      if (busy !== 32'h0) begin errors++; $display("FAIL mid_reset_busy: got %h want 00000000", busy); end
      checks++;
      if (q[1] !== 32'h0) begin errors++; $display("FAIL mid_reset_q1: got %h want 00000000", q[1]); end
      #1 rst = 1'b0;
   endtask

   task automatic test_random();
      logic [4:0] wa, ra;
      for (int n = 0; n < 400; n++) begin
         wa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
         ra = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
         drive(bit'($urandom_range(0, 1)), wa, $urandom, bit'($urandom_range(0, 1)), ra);
         #1;
         checks++;
         if (rsv_stall !== model_stall()) begin
            errors++; $display("FAIL rnd_stall[%0d]: got %b want %b", n, rsv_stall, model_stall());
         end
         tick();
         checks++;
         if (busy !== model_busy_vec()) begin
            errors++; $display("FAIL rnd_busy[%0d]: got %h want %h", n, busy, model_busy_vec());
         end
         for (int i = 0; i < 32; i++) begin
            checks++;
            if (q[i] !== m_reg[i]) begin
               errors++; $display("FAIL rnd_q%0d[%0d]: got %h want %h", i, n, q[i], m_reg[i]);
            end
         end
      end
      drive(0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0, 0);
      model_reset();
      #2;
      test_reset();
      test_write_readback();
      test_reserve_stall();
      test_simultaneous();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
